seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Captures the segment and digit-select lines of a multiplexed, scanned 7-segment display and recovers per-digit BCD values. This is the inverse of our BCD-to-7-segment decode path. It sits on the observation side of a display bus, in loopback self-test or when snooping a foreign display driver. Each incoming glyph must stay stable for a set number of scan samples before it is committed. A committed change is announced with a one-cycle update pulse.

## Interface
- NUM_DIGITS, 4: number of scanned digits; legal range 1..8.
- STABLE_CNT, 3: consecutive identical samples required per digit before commit; legal range 1..15.
- COMMON_ANODE, 0: when nonzero, seg_in and dp_in are active-low and are inverted on entry. dig_sel is always active-high.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment lines {a,b,c,d,e,f,g}, asynchronous to clk.
- dp_in  in  1  decimal point line, asynchronous.
- dig_sel  in  NUM_DIGITS  one-hot digit strobe, asynchronous.
- bcd_out  out  4*NUM_DIGITS  committed value per digit; digit i is at [4i+3:4i].
- dp_out  out  NUM_DIGITS  committed decimal point per digit.
- digit_err  out  NUM_DIGITS  committed glyph is not a recognised pattern.
- upd_valid  out  1  one-cycle pulse when a digit's committed state changes.
- upd_idx  out  3  index of the changed digit; meaningful only while upd_valid is high.

## Operation
- **Input synchronisation:** seg_in, dp_in and dig_sel pass through a 2-flop synchroniser. After polarity normalisation they form the 8-bit sample {dp, a..g}.
- **Sample qualification:** a sample cycle occurs only when the synchronised dig_sel has exactly one bit set.
  - dig_sel all-zero or multi-hot: the cycle is ignored.
  - An ignored cycle does not reset any digit's counter.
- **Per-digit tracking:** each digit i holds a candidate cand[i] (8 bits) and a saturating counter cnt[i].
  - On a sample for digit i with sample == cand[i]: cnt[i] increments, saturating at STABLE_CNT.
  - Otherwise: cand[i] loads the sample and cnt[i] is set to 1.
  - Samples for other digits leave digit i untouched.
- **Commit condition:** a commit occurs on the sample where cnt[i] becomes STABLE_CNT (a transition into that value, not the saturated hold). The commit decodes cand[i] into (bcd, err, dp).
  - If the decoded result differs from the committed state, bcd_out, digit_err and dp_out for digit i update.
  - On such a change, upd_valid pulses and upd_idx = i.
  - An identical re-commit produces no pulse.
- **Glyph decode:**
  - Digits 0..9 map to their values with err=0. Patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Dash (0000001) decodes to 4'hF with err=0.
  - All-off (0000000) decodes to 4'hF with err=0, meaning blank.
  - Any other pattern decodes to 4'hF with err=1.
  - dp passes straight through.
- **Reset:** rst_n low clears the state asynchronously.
  - Outputs: bcd_out all 4'hF, dp_out 0, digit_err 0, upd_valid 0, upd_idx 0.
  - Internal: all cand 0, all cnt 0, synchronisers 0.
  - Reset mid-qualification discards partial counts. After release, every digit must requalify with STABLE_CNT fresh samples.

## Timing
- An input stable before rising edge k, with dig_sel continuously on digit i, is committed at edge k+1+STABLE_CNT.
- That is, bcd_out changes after STABLE_CNT+2 edges. upd_valid is high for exactly the cycle following the commit edge.
- At most one digit commits per cycle, so upd_valid never needs to report two digits at once.
- upd_valid is registered, not combinational.
- A glitch (one differing sample) restarts qualification. It costs a fresh STABLE_CNT samples after the glitch.
- With STABLE_CNT=1, the first qualified sample commits.

## Configuration
- SEG7_ALT_GLYPH_EN defined: three alternate glyphs are additionally accepted, all with err=0.
  - 6 without segment a: 0011111.
  - 7 with segment f: 1110010.
  - 9 without segment d: 1110011.
- SEG7_ALT_GLYPH_EN undefined: those three patterns decode as unknown (4'hF, err=1).

## Structure
- Package seg7_pkg holds:
  - the ten digit glyph constants;
  - SEG7_DASH and SEG7_BLANK;
  - the alternate glyph constants;
  - BCD_BLANK = 4'hF;
  - the segment-order definition.
- Sub-module seg7_glyph_decode: purely combinational; 7-bit pattern in, 4-bit bcd and err out. It is instantiated once, on the committing digit's candidate.

## Test plan
- **Reset values:** assert rst_n low mid-scan with NUM_DIGITS=4. Expect bcd_out=16'hFFFF, digit_err=0, dp_out=0, and no upd_valid until STABLE_CNT fresh samples.
- **Steady scan:** rotate dig_sel across "1234" (seg 0110000, 1101101, 1111001, 0110011), 5 cycles each, STABLE_CNT=3. Expect bcd_out=16'h4321, four upd_valid pulses with upd_idx 0..3, then no further pulses.
- **Glitch filter:** hold digit 0 on 7 (1110000), inject one sample of 8 (1111111), then resume 7. Expect no change and no pulse. Inject 8 for 3 samples: expect bcd[3:0]=8 and one pulse.
- **Illegal glyph and dash:**
  - 1000001 for 3 samples gives bcd=F, err=1.
  - 0000001 gives bcd=F with err falling to 0 and a pulse.
- **Invalid strobe:** dig_sel=4'b0000 and 4'b0110 interleaved between samples. Expect them ignored, and commits timed only by valid samples.
- **Alternate glyph:** seg 0011111. With SEG7_ALT_GLYPH_EN, expect bcd=6, err=0. Without it, expect bcd=F, err=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the scanned 7-segment capture path.
// Segment patterns are written {a,b,c,d,e,f,g}: segment a is bit 6, g is bit 0.
// The captured sample appends the decimal point above the segments as bit 7.
package seg7_pkg;

    // Bit position of each segment inside a 7-bit pattern.
    typedef enum int unsigned {
        SEG_G = 0,
        SEG_F = 1,
        SEG_E = 2,
        SEG_D = 3,
        SEG_C = 4,
        SEG_B = 5,
        SEG_A = 6
    } seg7_seg_e;

    localparam int SEG7_DP_BIT = 7;

    // Standard digit glyphs
    localparam logic [6:0] SEG7_GLYPH_0 = 7'b1111110;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'b0110000;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'b1101101;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'b1111001;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'b0110011;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'b1011011;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'b1011111;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'b1110000;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'b1111111;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'b1111011;

    // Non-digit glyphs that are still legal
    localparam logic [6:0] SEG7_DASH  = 7'b0000001;
    localparam logic [6:0] SEG7_BLANK = 7'b0000000;

    // Alternate renderings some drivers use
    localparam logic [6:0] SEG7_ALT_6 = 7'b0011111;
    localparam logic [6:0] SEG7_ALT_7 = 7'b1110010;
    localparam logic [6:0] SEG7_ALT_9 = 7'b1110011;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Committed per-digit state
    typedef struct packed {
        logic [3:0] bcd;
        logic       err;
        logic       dp;
    } seg7_state_t;

    localparam seg7_state_t SEG7_STATE_RESET = '{bcd: BCD_BLANK, err: 1'b0, dp: 1'b0};

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational 7-segment pattern to BCD decoder.
// Build option: define SEG7_ALT_GLYPH_EN to also accept the alternate
// renderings of 6, 7 and 9; otherwise those patterns are flagged as unknown.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       err
);

    // Table lookup; anything not listed is an unrecognised glyph.
    always_comb begin
        bcd = BCD_BLANK;
        err = 1'b1;
        case (pattern)
            SEG7_GLYPH_0: begin bcd = 4'd0; err = 1'b0; end
            SEG7_GLYPH_1: begin bcd = 4'd1; err = 1'b0; end
            SEG7_GLYPH_2: begin bcd = 4'd2; err = 1'b0; end
            SEG7_GLYPH_3: begin bcd = 4'd3; err = 1'b0; end
            SEG7_GLYPH_4: begin bcd = 4'd4; err = 1'b0; end
            SEG7_GLYPH_5: begin bcd = 4'd5; err = 1'b0; end
            SEG7_GLYPH_6: begin bcd = 4'd6; err = 1'b0; end
            SEG7_GLYPH_7: begin bcd = 4'd7; err = 1'b0; end
            SEG7_GLYPH_8: begin bcd = 4'd8; err = 1'b0; end
            SEG7_GLYPH_9: begin bcd = 4'd9; err = 1'b0; end
            SEG7_DASH:    begin bcd = BCD_BLANK; err = 1'b0; end
            SEG7_BLANK:   begin bcd = BCD_BLANK; err = 1'b0; end
`ifdef SEG7_ALT_GLYPH_EN
            SEG7_ALT_6:   begin bcd = 4'd6; err = 1'b0; end
            SEG7_ALT_7:   begin bcd = 4'd7; err = 1'b0; end
            SEG7_ALT_9:   begin bcd = 4'd9; err = 1'b0; end
`endif
            default:      begin bcd = BCD_BLANK; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: snoops a multiplexed 7-segment display bus and recovers
// the per-digit BCD value, decimal point and glyph-error flag. A glyph must be
// seen STABLE_CNT times on its digit strobe before it is committed.
// Build option: SEG7_ALT_GLYPH_EN (see seg7_glyph_decode).
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_CNT   = 3,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic                    dp_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    upd_valid,
    output logic [2:0]              upd_idx
);

    localparam logic [3:0] STABLE_VAL = 4'(STABLE_CNT);
    localparam logic [7:0] POL_MASK   = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;

    logic [7:0]            sample_meta_reg, sample_sync_reg;
    logic [NUM_DIGITS-1:0] sel_meta_reg, sel_sync_reg;
    logic [7:0]            sample;
    logic                  sample_valid;
    logic [2:0]            sel_idx;
    logic [3:0]            dec_bcd;
    logic                  dec_err;
    seg7_state_t           dec_state;
    logic [NUM_DIGITS-1:0] change_vec;
    logic                  upd_valid_reg;
    logic [2:0]            upd_idx_reg;

    // Two-flop synchroniser for all asynchronous display lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_meta_reg <= '0;
            sample_sync_reg <= '0;
            sel_meta_reg    <= '0;
            sel_sync_reg    <= '0;
        end else begin
            sample_meta_reg <= {dp_in, seg_in};
            sample_sync_reg <= sample_meta_reg;
            sel_meta_reg    <= dig_sel;
            sel_sync_reg    <= sel_meta_reg;
        end
    end

    // Polarity is normalised after synchronisation so nothing sits ahead of the first flop.
    assign sample       = sample_sync_reg ^ POL_MASK;
    assign sample_valid = $onehot(sel_sync_reg);

    // Index of the strobed digit; only used when the strobe is one-hot.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_sync_reg[i]) sel_idx = 3'(i);
        end
    end

    // Only one digit can sample per cycle, so one decoder on the live sample
    // serves whichever digit commits (its candidate equals this sample then).
    seg7_glyph_decode u_decode (
        .pattern (sample[6:0]),
        .bcd     (dec_bcd),
        .err     (dec_err)
    );

    assign dec_state = '{bcd: dec_bcd, err: dec_err, dp: sample[SEG7_DP_BIT]};

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [7:0]  cand_reg;
        logic [3:0]  cnt_reg;
        logic [3:0]  cnt_next;
        seg7_state_t state_reg;
        logic        hit, match, saturated, commit;

        assign hit       = sample_valid && sel_sync_reg[gi];
        assign match     = (sample == cand_reg);
        assign saturated = (cnt_reg == STABLE_VAL);
        assign cnt_next  = !match ? 4'd1 : (saturated ? cnt_reg : cnt_reg + 4'd1);
        // Commit only on the transition into STABLE_CNT, never on the saturated hold.
        assign commit        = hit && (cnt_next == STABLE_VAL) && !(match && saturated);
        assign change_vec[gi] = commit && (dec_state != state_reg);

        // Candidate tracking and committed state for this digit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cand_reg  <= '0;
                cnt_reg   <= '0;
                state_reg <= SEG7_STATE_RESET;
            end else begin
                if (hit) begin
                    cand_reg <= sample;
                    cnt_reg  <= cnt_next;
                end
                if (change_vec[gi]) begin
                    state_reg <= dec_state;
                end
            end
        end

        assign bcd_out[4*gi +: 4] = state_reg.bcd;
        assign dp_out[gi]         = state_reg.dp;
        assign digit_err[gi]      = state_reg.err;
    end

    // Registered update announcement; at most one digit changes per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_reg <= 1'b0;
            upd_idx_reg   <= '0;
        end else begin
            upd_valid_reg <= |change_vec;
            if (|change_vec) begin
                upd_idx_reg <= sel_idx;
            end
        end
    end

    assign upd_valid = upd_valid_reg;
    assign upd_idx   = upd_idx_reg;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: scoreboard bench for seg7_scan_capture (4 digits,
// STABLE_CNT=3, common cathode). The reference model counts unbounded runs of
// identical samples per digit and looks glyphs up in a plain table.
module tb_seg7_scan_capture;

    localparam int ND = 4;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_in = '0;
    logic          dp_in = 1'b0;
    logic [ND-1:0] dig_sel = '0;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] dp_out;
    logic [ND-1:0] digit_err;
    logic          upd_valid;
    logic [2:0]    upd_idx;

    seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CNT(ST), .COMMON_ANODE(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dp_in     (dp_in),
        .dig_sel   (dig_sel),
        .bcd_out   (bcd_out),
        .dp_out    (dp_out),
        .digit_err (digit_err),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges++;

    int errors = 0;
    int checks = 0;

    // Glyph table straight from the digit pattern list.
    logic [6:0] glyph_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                   7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    typedef struct {
        int              idx;
        int              when;
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0] m_cand [ND];
    int         m_run  [ND];
    logic [3:0] m_bcd  [ND];
    logic       m_err  [ND];
    logic       m_dp   [ND];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int v = 0; v < 10; v++) if (p == glyph_tab[v]) return {1'b0, 4'(v)};
        if (p == 7'b0000001 || p == 7'b0000000) return {1'b0, 4'hF};
`ifdef SEG7_ALT_GLYPH_EN
        if (p == 7'b0011111) return {1'b0, 4'd6};
        if (p == 7'b1110010) return {1'b0, 4'd7};
        if (p == 7'b1110011) return {1'b0, 4'd9};
`endif
        return {1'b1, 4'hF};
    endfunction

    function automatic logic [4*ND-1:0] m_bcd_vec();
        logic [4*ND-1:0] v;
        for (int i = 0; i < ND; i++) v[4*i +: 4] = m_bcd[i];
        return v;
    endfunction

    function automatic logic [ND-1:0] m_dp_vec();
        logic [ND-1:0] v;
        for (int i = 0; i < ND; i++) v[i] = m_dp[i];
        return v;
    endfunction

    function automatic logic [ND-1:0] m_err_vec();
        logic [ND-1:0] v;
        for (int i = 0; i < ND; i++) v[i] = m_err[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_cand[i] = '0;
            m_run[i]  = 0;
            m_bcd[i]  = 4'hF;
            m_err[i]  = 1'b0;
            m_dp[i]   = 1'b0;
        end
    endtask

    // One driven cycle seen at edge t+1 becomes a sample two edges later, so a
    // resulting update is visible after edge t+3.
    task automatic model_step(input logic [ND-1:0] sel, input logic [7:0] s, input int t);
        int d;
        logic [4:0] dec;
        exp_t e;
        if ($countones(sel) != 1) return;
        d = 0;
        for (int i = 0; i < ND; i++) if (sel[i]) d = i;
        if (s == m_cand[d]) m_run[d]++;
        else begin
            m_cand[d] = s;
            m_run[d]  = 1;
        end
        if (m_run[d] == ST) begin
            dec = ref_decode(s[6:0]);
            if (dec[3:0] != m_bcd[d] || dec[4] != m_err[d] || s[7] != m_dp[d]) begin
                m_bcd[d] = dec[3:0];
                m_err[d] = dec[4];
                m_dp[d]  = s[7];
                e.idx  = d;
                e.when = t + 3;
                e.bcd  = m_bcd_vec();
                e.dp   = m_dp_vec();
                e.err  = m_err_vec();
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg, input logic dp, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            dig_sel = sel;
            seg_in  = seg;
            dp_in   = dp;
            model_step(sel, {dp, seg}, edges);
        end
    endtask

    task automatic idle(input int n);
        drive('0, 7'b0, 1'b0, n);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_bcd"}, 32'(bcd_out), 32'(m_bcd_vec()));
        check({tag, "_dp"},  32'(dp_out),  32'(m_dp_vec()));
        check({tag, "_err"}, 32'(digit_err), 32'(m_err_vec()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        dig_sel = '0;
        seg_in  = '0;
        dp_in   = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("rst_bcd", 32'(bcd_out), 32'h0000FFFF);
        check("rst_dp", 32'(dp_out), 32'h0);
        check("rst_err", 32'(digit_err), 32'h0);
        check("rst_upd_valid", 32'(upd_valid), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: compare every update pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (upd_valid) begin
                $display("upd idx=%0d bcd=%h dp=%b err=%b at edge %0d", upd_idx, bcd_out, dp_out, digit_err, edges);
                if (exp_q.size() == 0) begin
                    check("unexpected_upd", 32'(upd_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("upd_idx", 32'(upd_idx), 32'(e.idx));
                    check("upd_time", 32'(edges), 32'(e.when));
                    check("upd_bcd", 32'(bcd_out), 32'(e.bcd));
                    check("upd_dp", 32'(dp_out), 32'(e.dp));
                    check("upd_err", 32'(digit_err), 32'(e.err));
                end
            end else if (exp_q.size() != 0 && exp_q[0].when < edges) begin
                check("missing_upd", 32'(upd_valid), 32'h1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Steady scan of "1234", rotated twice; second pass must be silent.
        for (int pass = 0; pass < 2; pass++) begin
            drive(4'b0001, 7'b0110000, 1'b0, 5);
            drive(4'b0010, 7'b1101101, 1'b0, 5);
            drive(4'b0100, 7'b1111001, 1'b0, 5);
            drive(4'b1000, 7'b0110011, 1'b0, 5);
        end
        idle(5);
        check("scan_bcd_const", 32'(bcd_out), 32'h00004321);
        check_state("scan");

        // Glitch filter on digit 0
        drive(4'b0001, 7'b1110000, 1'b0, 5);
        drive(4'b0001, 7'b1111111, 1'b0, 1);
        drive(4'b0001, 7'b1110000, 1'b0, 5);
        idle(5);
        check("glitch_hold", 32'(bcd_out[3:0]), 32'h7);
        drive(4'b0001, 7'b1111111, 1'b0, 3);
        idle(5);
        check("glitch_commit8", 32'(bcd_out[3:0]), 32'h8);

        // Illegal glyph then dash, with the decimal point on
        drive(4'b0001, 7'b1000001, 1'b1, 3);
        idle(5);
        check("illegal_err", 32'({digit_err[0], bcd_out[3:0]}), 32'h1F);
        drive(4'b0001, 7'b0000001, 1'b1, 3);
        idle(5);
        check("dash_err", 32'({digit_err[0], bcd_out[3:0]}), 32'h0F);
        check("dash_dp", 32'(dp_out[0]), 32'h1);

        // Invalid strobes interleaved between three valid samples of 9 on digit 1
        for (int k = 0; k < 3; k++) begin
            drive(4'b0010, 7'b1111011, 1'b0, 1);
            drive(4'b0000, 7'b1111011, 1'b0, 1);
            drive(4'b0110, 7'b0000000, 1'b0, 1);
        end
        idle(5);
        check("strobe_bcd", 32'(bcd_out[7:4]), 32'h9);

        // Alternate glyph for 6 on digit 2
        drive(4'b0100, 7'b0011111, 1'b0, 3);
        idle(5);
`ifdef SEG7_ALT_GLYPH_EN
        check("alt6", 32'({digit_err[2], bcd_out[11:8]}), 32'h06);
`else
        check("alt6", 32'({digit_err[2], bcd_out[11:8]}), 32'h1F);
`endif
        check_state("directed");

        // Reset mid-qualification: partial count must be discarded.
        drive(4'b1000, 7'b1011011, 1'b0, 2);
        do_reset();
        drive(4'b1000, 7'b1011011, 1'b0, 3);
        idle(5);
        check("post_reset_5", 32'(bcd_out[15:12]), 32'h5);

        // Randomised scan traffic
        for (int n = 0; n < 400; n++) begin
            logic [ND-1:0] sel;
            logic [6:0]    g;
            int            pick;
            int            d;
            sel = '0;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    sel[$urandom_range(0, 1)] = 1'b1;
                    sel[$urandom_range(2, 3)] = 1'b1;
                end
            end else begin
                d = $urandom_range(0, ND - 1);
                sel[d] = 1'b1;
            end
            pick = $urandom_range(0, 15);
            case (pick)
                10: g = 7'b0000001;
                11: g = 7'b0000000;
                12: g = 7'b0011111;
                13: g = 7'b1110010;
                14: g = 7'b1110011;
                15: g = 7'($urandom);
                default: g = glyph_tab[pick];
            endcase
            drive(sel, g, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
        end

        idle(8);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check_state("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
